// File: rtl/disp_frame_builder.sv
// Display frame builder: converts a reaction-time count to BCD and streams
// MAX7219-style command words (init sequence, then one frame per value) over valid/ready.
module disp_frame_builder #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned CNT_W      = 14,
   parameter int unsigned INTENSITY  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] value_in,
   input  logic             value_valid,
   output logic [7:0]       byte_out,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic             word_end,
   output logic             busy,
   output logic             saturated
);

   localparam int unsigned LIMIT      = (NUM_DIGITS == 1) ? 9 :
                                        (NUM_DIGITS == 2) ? 99 :
                                        (NUM_DIGITS == 3) ? 999 : 9999;
   localparam int unsigned PTR_W      = 4;
   localparam int unsigned INIT_BYTES = 8;
   localparam int unsigned SEND_BYTES = 2 * NUM_DIGITS;
   localparam int unsigned CC_W       = $clog2(CNT_W + 1);

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_IDLE    = 2'd1,
      ST_CONVERT = 2'd2,
      ST_SEND    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] cnt_q, cnt_d;
   logic [CC_W-1:0]  conv_cnt_q, conv_cnt_d;
   logic [CNT_W-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic             pend_valid_q, pend_valid_d;
   logic [CNT_W-1:0] pend_val_q, pend_val_d;
   logic [7:0]       byte_out_q, byte_out_d;
   logic             byte_valid_q, byte_valid_d;
   logic             word_end_q, word_end_d;
   logic             busy_q, busy_d;
   logic             saturated_q, saturated_d;

   logic             xfer_c;
   logic             free_c;
   logic [PTR_W-1:0] total_c;
   logic [7:0]       byte_nxt_c;
   logic [15:0]      bcd_adj_c;
   logic [CNT_W-1:0] src_c;

   assign xfer_c  = byte_valid_q & byte_ready;
   // Output register may take a new byte when empty or being drained this cycle.
   assign free_c  = ~byte_valid_q | xfer_c;
   assign total_c = (state_q == ST_INIT) ? PTR_W'(INIT_BYTES) : PTR_W'(SEND_BYTES);

   // Byte selected by the stream pointer: even = address, odd = data.
   always_comb begin
      byte_nxt_c = 8'h00;
      if (state_q == ST_INIT) begin
         case (cnt_q[2:0])
            3'd0:    byte_nxt_c = 8'h0C;
            3'd1:    byte_nxt_c = 8'h01;
            3'd2:    byte_nxt_c = 8'h09;
            3'd3:    byte_nxt_c = 8'hFF;
            3'd4:    byte_nxt_c = 8'h0B;
            3'd5:    byte_nxt_c = 8'(NUM_DIGITS - 1);
            3'd6:    byte_nxt_c = 8'h0A;
            default: byte_nxt_c = {4'h0, 4'(INTENSITY)};
         endcase
      end else if (cnt_q[0]) begin
         byte_nxt_c = {4'h0, bcd_q[{cnt_q[2:1], 2'b00} +: 4]};
      end else begin
         byte_nxt_c = 8'(cnt_q[3:1]) + 8'd1;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      conv_cnt_d   = conv_cnt_q;
      bin_d        = bin_q;
      bcd_d        = bcd_q;
      pend_valid_d = pend_valid_q;
      pend_val_d   = pend_val_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = byte_valid_q;
      word_end_d   = word_end_q;
      saturated_d  = saturated_q;
      bcd_adj_c    = bcd_q;
      src_c        = pend_valid_q ? pend_val_q : value_in;

      if (value_valid && (state_q != ST_IDLE)) begin
         pend_valid_d = 1'b1;
         pend_val_d   = value_in;
      end

      case (state_q)
         ST_INIT, ST_SEND: begin
            if (free_c) begin
               if (cnt_q == total_c) begin
                  byte_valid_d = 1'b0;
                  word_end_d   = 1'b0;
                  cnt_d        = '0;
                  state_d      = ST_IDLE;
               end else begin
                  byte_valid_d = 1'b1;
                  byte_out_d   = byte_nxt_c;
                  word_end_d   = cnt_q[0];
                  cnt_d        = cnt_q + PTR_W'(1);
               end
            end
         end
         ST_IDLE: begin
            if (pend_valid_q || value_valid) begin
               if (32'(src_c) > LIMIT) begin
                  bin_d       = CNT_W'(LIMIT);
                  saturated_d = 1'b1;
               end else begin
                  bin_d       = src_c;
                  saturated_d = 1'b0;
               end
               // A strobe coinciding with a pending load refills pending.
               if (pend_valid_q) begin
                  pend_valid_d = value_valid;
                  pend_val_d   = value_valid ? value_in : pend_val_q;
               end
               bcd_d      = '0;
               conv_cnt_d = '0;
               state_d    = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            for (int i = 0; i < 4; i++) begin
               if (bcd_q[4*i +: 4] >= 4'd5) begin
                  bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
               end
            end
            bcd_d      = 16'({bcd_adj_c, bin_q[CNT_W-1]});
            bin_d      = CNT_W'({bin_q, 1'b0});
            conv_cnt_d = conv_cnt_q + CC_W'(1);
            // Present the first address byte straight out of the last shift cycle.
            if (conv_cnt_q == CC_W'(CNT_W - 1)) begin
               state_d      = ST_SEND;
               byte_valid_d = 1'b1;
               byte_out_d   = 8'h01;
               word_end_d   = 1'b0;
               cnt_d        = PTR_W'(1);
            end
         end
         default: state_d = ST_INIT;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_INIT;
         cnt_q        <= '0;
         conv_cnt_q   <= '0;
         bin_q        <= '0;
         bcd_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_val_q   <= '0;
         byte_out_q   <= 8'h00;
         byte_valid_q <= 1'b0;
         word_end_q   <= 1'b0;
         busy_q       <= 1'b1;
         saturated_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         conv_cnt_q   <= conv_cnt_d;
         bin_q        <= bin_d;
         bcd_q        <= bcd_d;
         pend_valid_q <= pend_valid_d;
         pend_val_q   <= pend_val_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         word_end_q   <= word_end_d;
         busy_q       <= busy_d;
         saturated_q  <= saturated_d;
      end
   end

   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign word_end   = word_end_q;
   assign busy       = busy_q;
   assign saturated  = saturated_q;

endmodule

// File: tb/tb_disp_frame_builder.sv
// Directed bench for disp_frame_builder: init sequence, conversion frames,
// clamping, back-pressure, pending overwrite and mid-frame reset.
module tb_disp_frame_builder;

   logic        clk;
   logic        rst;
   logic [13:0] value_in;
   logic        value_valid;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        word_end;
   logic        busy;
   logic        saturated;

   int n_cmp;
   int n_err;

   disp_frame_builder #(
      .NUM_DIGITS(4),
      .CNT_W     (14),
      .INTENSITY (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value_in   (value_in),
      .value_valid(value_valid),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .word_end   (word_end),
      .busy       (busy),
      .saturated  (saturated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drains one 8-byte stream with ready high; optional 5-cycle stall (with
   // two value strobes) while byte stall_idx is presented.
   task automatic get_frame(input string tag, input logic [63:0] exp, input int stall_idx);
      int         wait_c;
      logic [7:0] eb;
      for (int i = 0; i < 8; i++) begin
         wait_c = 0;
         while (byte_valid !== 1'b1 && wait_c < 200) begin
            tick();
            wait_c++;
         end
         if (i > 0) check($sformatf("%s gap%0d", tag, i), 32'(wait_c), 32'd0);
         eb = exp[63-8*i -: 8];
         if (i == stall_idx) begin
            byte_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               value_valid = (s == 1) || (s == 3);
               value_in    = (s == 1) ? 14'd100 : 14'd250;
               tick();
               value_valid = 1'b0;
               check($sformatf("%s stall%0d byte", tag, s), 32'(byte_out), 32'(eb));
               check($sformatf("%s stall%0d valid", tag, s), 32'(byte_valid), 32'd1);
            end
            byte_ready = 1'b1;
         end
         check($sformatf("%s valid%0d", tag, i), 32'(byte_valid), 32'd1);
         check($sformatf("%s byte%0d", tag, i), 32'(byte_out), 32'(eb));
         check($sformatf("%s wend%0d", tag, i), 32'(word_end), 32'(i % 2));
         tick();
      end
   endtask

   task automatic strobe(input logic [13:0] v);
      value_in    = v;
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      value_in    = '0;
      value_valid = 1'b0;
      byte_ready  = 1'b0;
      tick();
      tick();
      check("rst byte_valid", 32'(byte_valid), 32'd0);
      check("rst byte_out", 32'(byte_out), 32'd0);
      check("rst word_end", 32'(word_end), 32'd0);
      check("rst busy", 32'(busy), 32'd1);
      check("rst saturated", 32'(saturated), 32'd0);
      rst        = 1'b0;
      byte_ready = 1'b1;

      get_frame("init", 64'h0C01_09FF_0B03_0A08, -1);
      check("init done busy", 32'(busy), 32'd0);

      // 1234: latency, back-pressure on byte index 4, strobes 100 then 250 into pending
      strobe(14'd1234);
      lat = 1;
      while (byte_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      check("1234 latency", 32'(lat), 32'd15);
      check("1234 busy", 32'(busy), 32'd1);
      get_frame("f1234", 64'h0104_0203_0302_0401, 4);
      check("1234 saturated", 32'(saturated), 32'd0);

      get_frame("f250", 64'h0100_0205_0302_0400, -1);
      check("250 saturated", 32'(saturated), 32'd0);
      check("250 done busy", 32'(busy), 32'd0);
      tick();
      tick();
      check("no stale pending busy", 32'(busy), 32'd0);
      check("no stale pending valid", 32'(byte_valid), 32'd0);

      strobe(14'd12000);
      get_frame("f12000", 64'h0109_0209_0309_0409, -1);
      check("12000 saturated", 32'(saturated), 32'd1);

      strobe(14'd7);
      get_frame("f7", 64'h0107_0200_0300_0400, -1);
      check("7 saturated", 32'(saturated), 32'd0);

      strobe(14'd0);
      get_frame("f0", 64'h0100_0200_0300_0400, -1);

      // Reset during the second word of a frame, with a value waiting in pending
      strobe(14'd1234);
      lat = 0;
      while (byte_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      check("pre-rst byte0", 32'(byte_out), 32'h01);
      tick();
      check("pre-rst byte1", 32'(byte_out), 32'h04);
      value_in    = 14'd55;
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
      check("pre-rst byte2", 32'(byte_out), 32'h02);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("post-rst valid", 32'(byte_valid), 32'd0);
      check("post-rst busy", 32'(busy), 32'd1);
      get_frame("reinit", 64'h0C01_09FF_0B03_0A08, -1);
      check("reinit busy", 32'(busy), 32'd0);
      tick();
      tick();
      check("pending cleared busy", 32'(busy), 32'd0);
      check("pending cleared valid", 32'(byte_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
